// File: rtl/pr_region_decouple_ctrl.sv
// Partial-reconfiguration sequencer for the PR_NORTH region.
// Snoops the RM's AXI-MM master and AXI-Lite slave channels and counts
// outstanding transactions. On a host request it drains traffic, isolates
// the RM and holds it in reset while ICAP reloads. It then resets the new
// RM and re-attaches it.
// Ports:
//   axi_clk, axi_reset_n  - clock, async active-low reset
//   pr_req                - host level: 1 = reconfigure, 0 = reload done
//   mm_* / lite_*         - handshake snoop inputs
//   gate_new, decouple    - decoupler controls
//   rm_reset_n, pr_ready  - RM reset, ICAP go
//   state                 - 0 RUN, 1 DRAIN, 2 DECOUPLED, 3 RESET_RM
//   timeout_flag, proto_err, pr_count - sticky status and cycle count
module pr_region_decouple_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 65536,
   parameter int unsigned RESET_CYCLES   = 32,
   parameter int unsigned CNT_W          = 8
) (
   input  logic        axi_clk,
   input  logic        axi_reset_n,
   input  logic        pr_req,
   input  logic        mm_awvalid,
   input  logic        mm_awready,
   input  logic        mm_bvalid,
   input  logic        mm_bready,
   input  logic        mm_arvalid,
   input  logic        mm_arready,
   input  logic        mm_rvalid,
   input  logic        mm_rready,
   input  logic        mm_rlast,
   input  logic        lite_awvalid,
   input  logic        lite_awready,
   input  logic        lite_bvalid,
   input  logic        lite_bready,
   input  logic        lite_arvalid,
   input  logic        lite_arready,
   input  logic        lite_rvalid,
   input  logic        lite_rready,
   output logic        gate_new,
   output logic        decouple,
   output logic        rm_reset_n,
   output logic        pr_ready,
   output logic [1:0]  state,
   output logic        timeout_flag,
   output logic        proto_err,
   output logic [15:0] pr_count
);

   localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam int unsigned TMR_W = (TMO_W > RST_W) ? TMO_W : RST_W;
   localparam int unsigned NCNT  = 4;

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_DRAIN     = 2'd1,
      ST_DECOUPLED = 2'd2,
      ST_RESET_RM  = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [CNT_W-1:0]   cnt_q [NCNT];
   logic [CNT_W-1:0]   cnt_d [NCNT];
   logic [NCNT-1:0]    inc, dec;
   logic               cnt_err, all_idle, clr_cnt;
   logic               tflag_q, tflag_d, perr_q, perr_d;
   logic [15:0]        prc_q, prc_d;
   logic               gate_q, gate_d, dcpl_q, dcpl_d;
   logic               rstn_q, rstn_d, rdy_q, rdy_d;

   // Request/response handshakes: mm_wr, mm_rd, lite_wr, lite_rd
   assign inc = {lite_arvalid & lite_arready, lite_awvalid & lite_awready,
                 mm_arvalid & mm_arready,     mm_awvalid & mm_awready};
   assign dec = {lite_rvalid & lite_rready,   lite_bvalid & lite_bready,
                 mm_rvalid & mm_rready & mm_rlast, mm_bvalid & mm_bready};

   // Saturating outstanding counters; under/overflow is a protocol error
   always_comb begin
      cnt_err  = 1'b0;
      all_idle = 1'b1;
      for (int i = 0; i < NCNT; i++) begin
         cnt_d[i] = cnt_q[i];
         if (inc[i] && !dec[i]) begin
            if (cnt_q[i] == {CNT_W{1'b1}}) cnt_err = 1'b1;
            else                           cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end else if (dec[i] && !inc[i]) begin
            if (cnt_q[i] == '0) cnt_err = 1'b1;
            else                cnt_d[i] = cnt_q[i] - CNT_W'(1);
         end
         if (cnt_d[i] != '0) all_idle = 1'b0;
      end
   end

   // Next-state and registered-output decode
   always_comb begin
      state_d = state_q;
      timer_d = timer_q + TMR_W'(1);
      tflag_d = tflag_q;
      perr_d  = perr_q | cnt_err;
      prc_d   = prc_q;
      clr_cnt = 1'b0;
      case (state_q)
         ST_RUN: begin
            timer_d = '0;
            if (pr_req) begin
               state_d = ST_DRAIN;
               tflag_d = 1'b0;
               perr_d  = cnt_err;
            end
         end
         ST_DRAIN: begin
            if (all_idle) begin
               state_d = ST_DECOUPLED;
               timer_d = '0;
            end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
               state_d = ST_DECOUPLED;
               tflag_d = 1'b1;
               timer_d = '0;
            end
         end
         ST_DECOUPLED: begin
            timer_d = '0;
            if (!pr_req) begin
               state_d = ST_RESET_RM;
               clr_cnt = 1'b1;
            end
         end
         ST_RESET_RM: begin
            if (timer_q == TMR_W'(RESET_CYCLES - 1)) begin
               state_d = ST_RUN;
               timer_d = '0;
               prc_d   = prc_q + 16'd1;
            end
         end
         default: begin
            state_d = ST_RUN;
            timer_d = '0;
         end
      endcase
      gate_d = (state_d != ST_RUN);
      dcpl_d = (state_d == ST_DECOUPLED) || (state_d == ST_RESET_RM);
      rstn_d = (state_d == ST_RUN);
      rdy_d  = (state_d == ST_DECOUPLED);
   end

   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         state_q <= ST_RUN;
         timer_q <= '0;
         for (int i = 0; i < NCNT; i++) cnt_q[i] <= '0;
         tflag_q <= 1'b0;
         perr_q  <= 1'b0;
         prc_q   <= '0;
         gate_q  <= 1'b0;
         dcpl_q  <= 1'b0;
         rstn_q  <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         for (int i = 0; i < NCNT; i++) cnt_q[i] <= clr_cnt ? '0 : cnt_d[i];
         tflag_q <= tflag_d;
         perr_q  <= perr_d;
         prc_q   <= prc_d;
         gate_q  <= gate_d;
         dcpl_q  <= dcpl_d;
         rstn_q  <= rstn_d;
         rdy_q   <= rdy_d;
      end
   end

   assign gate_new     = gate_q;
   assign decouple     = dcpl_q;
   assign rm_reset_n   = rstn_q;
   assign pr_ready     = rdy_q;
   assign state        = state_q;
   assign timeout_flag = tflag_q;
   assign proto_err    = perr_q;
   assign pr_count     = prc_q;

endmodule

// File: tb/tb_pr_region_decouple_ctrl.sv
// Bench for pr_region_decouple_ctrl: directed scenarios followed by random
// traffic, every cycle compared against a behavioural reference model.
module tb_pr_region_decouple_ctrl;

   localparam int TO   = 16;
   localparam int RC   = 32;
   localparam int CW   = 3;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst_n;
   logic pr_req;
   logic mm_awvalid, mm_awready, mm_bvalid, mm_bready;
   logic mm_arvalid, mm_arready, mm_rvalid, mm_rready, mm_rlast;
   logic lite_awvalid, lite_awready, lite_bvalid, lite_bready;
   logic lite_arvalid, lite_arready, lite_rvalid, lite_rready;
   logic gate_new, decouple, rm_reset_n, pr_ready, timeout_flag, proto_err;
   logic [1:0]  state;
   logic [15:0] pr_count;

   int checks = 0;
   int errors = 0;

   // reference model
   int m_cnt [4];
   int m_state, m_age, m_hold, m_prc;
   bit m_tflag, m_perr, m_rstn;

   pr_region_decouple_ctrl #(.TIMEOUT_CYCLES(TO), .RESET_CYCLES(RC), .CNT_W(CW)) dut (
      .axi_clk(clk), .axi_reset_n(rst_n), .pr_req(pr_req),
      .mm_awvalid(mm_awvalid), .mm_awready(mm_awready),
      .mm_bvalid(mm_bvalid), .mm_bready(mm_bready),
      .mm_arvalid(mm_arvalid), .mm_arready(mm_arready),
      .mm_rvalid(mm_rvalid), .mm_rready(mm_rready), .mm_rlast(mm_rlast),
      .lite_awvalid(lite_awvalid), .lite_awready(lite_awready),
      .lite_bvalid(lite_bvalid), .lite_bready(lite_bready),
      .lite_arvalid(lite_arvalid), .lite_arready(lite_arready),
      .lite_rvalid(lite_rvalid), .lite_rready(lite_rready),
      .gate_new(gate_new), .decouple(decouple), .rm_reset_n(rm_reset_n),
      .pr_ready(pr_ready), .state(state), .timeout_flag(timeout_flag),
      .proto_err(proto_err), .pr_count(pr_count));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_bus();
      {mm_awvalid, mm_awready, mm_bvalid, mm_bready} = '0;
      {mm_arvalid, mm_arready, mm_rvalid, mm_rready, mm_rlast} = '0;
      {lite_awvalid, lite_awready, lite_bvalid, lite_bready} = '0;
      {lite_arvalid, lite_arready, lite_rvalid, lite_rready} = '0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_state = 0; m_age = 0; m_hold = 0; m_prc = 0;
      m_tflag = 0; m_perr = 0; m_rstn = 0;
   endtask

   // One clock of the reference behaviour, from the inputs seen at the edge
   task automatic model_step();
      int up [4];
      int dn [4];
      int n  [4];
      int total;
      bit err;
      up[0] = int'(mm_awvalid && mm_awready);   dn[0] = int'(mm_bvalid && mm_bready);
      up[1] = int'(mm_arvalid && mm_arready);   dn[1] = int'(mm_rvalid && mm_rready && mm_rlast);
      up[2] = int'(lite_awvalid && lite_awready); dn[2] = int'(lite_bvalid && lite_bready);
      up[3] = int'(lite_arvalid && lite_arready); dn[3] = int'(lite_rvalid && lite_rready);
      err = 0; total = 0;
      for (int i = 0; i < 4; i++) begin
         n[i] = m_cnt[i] + up[i] - dn[i];
         if (n[i] < 0)    begin n[i] = 0;    err = 1; end
         if (n[i] > CMAX) begin n[i] = CMAX; err = 1; end
         total += n[i];
      end
      case (m_state)
         0: if (pr_req) begin m_state = 1; m_age = 0; m_tflag = 0; m_perr = 0; end
         1: begin
            if (total == 0) m_state = 2;
            else if (m_age == TO - 1) begin m_state = 2; m_tflag = 1; end
            else m_age++;
         end
         2: if (!pr_req) begin
            m_state = 3; m_hold = 0;
            for (int i = 0; i < 4; i++) n[i] = 0;
         end
         default: begin
            if (m_hold == RC - 1) begin m_state = 0; m_prc = (m_prc + 1) % 65536; end
            else m_hold++;
         end
      endcase
      if (err) m_perr = 1;
      for (int i = 0; i < 4; i++) m_cnt[i] = n[i];
      m_rstn = (m_state == 0);
   endtask

   task automatic check_all();
      chk("state",        16'(state),        16'(m_state));
      chk("gate_new",     16'(gate_new),     16'(m_state != 0));
      chk("decouple",     16'(decouple),     16'(m_state >= 2));
      chk("rm_reset_n",   16'(rm_reset_n),   16'(m_rstn));
      chk("pr_ready",     16'(pr_ready),     16'(m_state == 2));
      chk("timeout_flag", 16'(timeout_flag), 16'(m_tflag));
      chk("proto_err",    16'(proto_err),    16'(m_perr));
      chk("pr_count",     pr_count,          16'(m_prc));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   initial begin
      rst_n = 1'b1; pr_req = 1'b0; idle_bus();
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_state", 16'(state), 16'd0);
      chk("rst_rm_reset_n", 16'(rm_reset_n), 16'd0);
      chk("rst_decouple", 16'(decouple), 16'd0);
      check_all();
      @(posedge clk); #1 rst_n = 1'b1;
      tick();
      chk("rstn_after_release", 16'(rm_reset_n), 16'd1);

      // idle bus reconfiguration
      pr_req = 1'b1;
      tick(); chk("t1_gate", 16'(gate_new), 16'd1); chk("t1_drain", 16'(state), 16'd1);
      tick(); chk("t1_dcpl", 16'(decouple), 16'd1); chk("t1_rdy", 16'(pr_ready), 16'd1);
      chk("t1_state2", 16'(state), 16'd2);
      pr_req = 1'b0;
      repeat (RC) tick();
      chk("t1_still_reset", 16'(state), 16'd3);
      tick();
      chk("t1_run", 16'(state), 16'd0); chk("t1_count", pr_count, 16'd1);

      // three writes outstanding, responses spread through the drain
      mm_awvalid = 1'b1; mm_awready = 1'b1;
      repeat (3) tick();
      idle_bus(); pr_req = 1'b1;
      tick();
      for (int k = 1; k <= 12; k++) begin
         mm_bvalid = (k % 4 == 0); mm_bready = mm_bvalid;
         tick();
         if (k < 12) chk("t2_in_drain", 16'(state), 16'd1);
      end
      idle_bus();
      chk("t2_dcpl", 16'(state), 16'd2); chk("t2_no_tmo", 16'(timeout_flag), 16'd0);
      pr_req = 1'b0;
      repeat (RC + 1) tick();

      // read with no RLAST forces the drain timeout
      mm_arvalid = 1'b1; mm_arready = 1'b1; tick();
      idle_bus(); mm_rvalid = 1'b1; mm_rready = 1'b1; tick();
      idle_bus(); pr_req = 1'b1;
      tick();
      repeat (TO - 1) tick();
      chk("t3_pre_tmo", 16'(state), 16'd1);
      tick();
      chk("t3_dcpl", 16'(state), 16'd2); chk("t3_tmo", 16'(timeout_flag), 16'd1);
      pr_req = 1'b0;
      repeat (RC + 1) tick();
      chk("t3_sticky", 16'(timeout_flag), 16'd1);
      pr_req = 1'b1; tick();
      chk("t3_cleared", 16'(timeout_flag), 16'd0);
      tick(); pr_req = 1'b0;
      repeat (RC + 1) tick();

      // simultaneous AW and B, then an unmatched B
      mm_awvalid = 1'b1; mm_awready = 1'b1; tick();
      mm_bvalid = 1'b1; mm_bready = 1'b1; tick();
      mm_awvalid = 1'b0; tick();
      chk("t4_no_err", 16'(proto_err), 16'd0);
      tick();
      chk("t4_underflow", 16'(proto_err), 16'd1);
      idle_bus(); pr_req = 1'b1;
      tick(); tick();
      chk("t4_idle_drain", 16'(state), 16'd2);
      pr_req = 1'b0;
      repeat (RC + 1) tick();

      // counter saturation
      lite_awvalid = 1'b1; lite_awready = 1'b1;
      repeat (CMAX) tick();
      chk("sat_no_err", 16'(proto_err), 16'd0);
      tick();
      chk("sat_err", 16'(proto_err), 16'd1);
      idle_bus(); pr_req = 1'b1;
      repeat (TO + 1) tick();
      pr_req = 1'b0;
      repeat (RC + 1) tick();

      // async reset partway through RESET_RM
      pr_req = 1'b1; tick(); tick();
      pr_req = 1'b0; repeat (10) tick();
      chk("t5_in_reset_rm", 16'(state), 16'd3);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("t5_state", 16'(state), 16'd0);
      chk("t5_dcpl", 16'(decouple), 16'd0);
      chk("t5_rstn_low", 16'(rm_reset_n), 16'd0);
      check_all();
      @(posedge clk); #1;
      chk("t5_rstn_held", 16'(rm_reset_n), 16'd0);
      rst_n = 1'b1;
      tick();
      chk("t5_rstn_rise", 16'(rm_reset_n), 16'd1);

      // request held high through RESET_RM
      pr_req = 1'b1; tick(); tick();
      pr_req = 1'b0; tick();
      pr_req = 1'b1;
      repeat (RC - 1) tick();
      chk("t6_reset_rm", 16'(state), 16'd3);
      tick();
      chk("t6_run", 16'(state), 16'd0); chk("t6_count", pr_count, 16'd1);
      tick();
      chk("t6_redrain", 16'(state), 16'd1);
      tick(); pr_req = 1'b0;
      repeat (RC + 1) tick();
      chk("t6_count2", pr_count, 16'd2);

      // random traffic and requests
      for (int c = 0; c < 4000; c++) begin
         mm_awvalid   = ($urandom_range(0, 3) == 0); mm_awready   = $urandom_range(0, 1) == 1;
         mm_bvalid    = ($urandom_range(0, 3) == 0); mm_bready    = $urandom_range(0, 1) == 1;
         mm_arvalid   = ($urandom_range(0, 3) == 0); mm_arready   = $urandom_range(0, 1) == 1;
         mm_rvalid    = ($urandom_range(0, 2) == 0); mm_rready    = $urandom_range(0, 1) == 1;
         mm_rlast     = ($urandom_range(0, 2) == 0);
         lite_awvalid = ($urandom_range(0, 4) == 0); lite_awready = $urandom_range(0, 1) == 1;
         lite_bvalid  = ($urandom_range(0, 4) == 0); lite_bready  = $urandom_range(0, 1) == 1;
         lite_arvalid = ($urandom_range(0, 4) == 0); lite_arready = $urandom_range(0, 1) == 1;
         lite_rvalid  = ($urandom_range(0, 4) == 0); lite_rready  = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 29) == 0) pr_req = ~pr_req;
         tick();
      end
      idle_bus(); pr_req = 1'b0;
      repeat (RC + TO + 4) tick();
      chk("final_run", 16'(state), 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
